// File: rtl/sram_spi_master.sv
// sram_spi_master: SPI mode-0 master for 23LC-class serial SRAM.
//   Runs entirely on clk; SCLK is produced by a divider that toggles every
//   CLK_DIV clk cycles while a transaction is active. Supports READ (0x03),
//   WRITE (0x02), RDSR (0x05) and WRSR (0x01). Other opcodes are ignored.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start, inst         command request (sampled in IDLE) and opcode
//   address             SRAM address (ADDR_BYTES bytes), captured at start
//   byte_length         data bytes for READ/WRITE, captured at start
//   wr_data/valid/ready write byte stream; transfer stalls until wr_valid
//   rd_data/valid       received byte, one-cycle valid pulse per byte
//   busy, done          transaction in progress / one-cycle end pulse
//   cs_n, sclk, mosi    SPI outputs (sclk idles low)
//   miso                SPI input
//
// Optional build macro: SRAM_SPI_INIT_SEQ_EN
//   When defined, the block issues WRSR 0x40 (sequential mode) on its own
//   after reset release, with no done pulse and no wr_ready activity.
module sram_spi_master #(
    parameter int ADDR_BYTES = 3,
    parameter int CLK_DIV    = 2,
    parameter int LEN_W      = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              inst,
    input  logic [8*ADDR_BYTES-1:0] address,
    input  logic [LEN_W-1:0]        byte_length,
    input  logic [7:0]              wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    cs_n,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CS_SETUP = 3'd1;
    localparam logic [2:0] S_CMD      = 3'd2;
    localparam logic [2:0] S_ADDR     = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;
    localparam logic [2:0] S_CS_HOLD  = 3'd5;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] INIT_SR  = 8'h40;

`ifdef SRAM_SPI_INIT_SEQ_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    logic [2:0]       state;
    logic [DW-1:0]    div_cnt;
    logic             tick;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [1:0]       addr_left;
    logic [AW-1:0]    addr_sr;
    logic [7:0]       tx_sr;
    logic [6:0]       rx_sr;
    logic             op_rw, op_rd, op_wr;
    logic             need_load;
    logic             init_pend, init_run;
    logic             dec_rw, dec_rd, dec_wr, dec_ok;
    logic             last_bit;
    logic             load_addr, go_data;

    assign dec_rw = (inst == OP_READ) || (inst == OP_WRITE);
    assign dec_rd = (inst == OP_READ) || (inst == OP_RDSR);
    assign dec_wr = (inst == OP_WRITE) || (inst == OP_WRSR);
    assign dec_ok = dec_rd || dec_wr;

    // The divider is frozen while waiting for a write byte, so sclk stays low
    // and a full half-period of mosi setup follows the handshake.
    assign tick     = (state != S_IDLE) && !need_load && (div_cnt == DW'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == 3'd7);
    assign mosi     = tx_sr[7];

    // What follows the byte that is finishing (used on its last falling edge).
    always_comb begin
        load_addr = 1'b0;
        go_data   = 1'b0;
        case (state)
            S_CMD:  begin
                load_addr = op_rw;
                go_data   = !op_rw;
            end
            S_ADDR: begin
                load_addr = (addr_left != 2'd0);
                go_data   = (addr_left == 2'd0) && (byte_cnt != '0);
            end
            S_DATA: go_data = (byte_cnt > LEN_W'(1));
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            addr_left <= '0;
            addr_sr   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            op_rw     <= 1'b0;
            op_rd     <= 1'b0;
            op_wr     <= 1'b0;
            need_load <= 1'b0;
            init_pend <= INIT_EN;
            init_run  <= 1'b0;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            rd_data   <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;

            if (state == S_IDLE || need_load || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (init_pend) begin
                        init_pend <= 1'b0;
                        init_run  <= 1'b1;
                        op_rw     <= 1'b0;
                        op_rd     <= 1'b0;
                        op_wr     <= 1'b1;
                        byte_cnt  <= LEN_W'(1);
                        tx_sr     <= OP_WRSR;
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_CS_SETUP;
                    end else if (start && dec_ok) begin
                        op_rw    <= dec_rw;
                        op_rd    <= dec_rd;
                        op_wr    <= dec_wr;
                        byte_cnt <= dec_rw ? byte_length : LEN_W'(1);
                        addr_sr  <= address;
                        tx_sr    <= inst;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CS_SETUP;
                    end
                end

                // First opcode bit is already on mosi; this tick is the first rising edge.
                S_CS_SETUP: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        state <= S_CMD;
                    end
                end

                S_CMD, S_ADDR, S_DATA: begin
                    if (need_load) begin
                        if (wr_valid) begin
                            tx_sr     <= wr_data;
                            need_load <= 1'b0;
                            wr_ready  <= 1'b0;
                        end
                    end else if (tick) begin
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[5:0], miso};
                            if (state == S_DATA && op_rd && last_bit) begin
                                rd_data  <= {rx_sr, miso};
                                rd_valid <= 1'b1;
                            end
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (!last_bit) begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                            end else begin
                                if (state == S_DATA)
                                    byte_cnt <= byte_cnt - 1'b1;
                                if (load_addr) begin
                                    tx_sr     <= addr_sr[AW-1 -: 8];
                                    addr_sr   <= addr_sr << 8;
                                    addr_left <= (state == S_CMD) ? 2'(ADDR_BYTES - 1) : addr_left - 1'b1;
                                    state     <= S_ADDR;
                                end else if (go_data) begin
                                    state <= S_DATA;
                                    if (op_wr && !init_run) begin
                                        tx_sr     <= '0;
                                        need_load <= 1'b1;
                                        wr_ready  <= 1'b1;
                                    end else begin
                                        tx_sr <= init_run ? INIT_SR : 8'h00;
                                    end
                                end else begin
                                    tx_sr <= '0;
                                    state <= S_CS_HOLD;
                                end
                            end
                        end
                    end
                end

                S_CS_HOLD: begin
                    if (tick) begin
                        cs_n     <= 1'b1;
                        busy     <= 1'b0;
                        done     <= !init_run;
                        init_run <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_spi_master.sv
// tb_sram_spi_master: directed bench for sram_spi_master with default
// parameters (3 address bytes, CLK_DIV=2, 24-bit length).
// A small SPI slave model logs mosi bytes on sclk rising edges and serves
// miso from a per-transaction response table.
module tb_sram_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  inst = '0;
    logic [23:0] address = '0;
    logic [23:0] byte_length = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;

    sram_spi_master #(.ADDR_BYTES(3), .CLK_DIV(2), .LEN_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .inst(inst), .address(address),
        .byte_length(byte_length), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
        .miso(miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI slave model / monitors ----------------
    int         total_edges = 0;
    int         bitph = 0;
    int         mosi_n = 0;
    int         rd_n = 0;
    int         done_n = 0;
    int         hs_n = 0;
    logic [7:0] sh = '0;
    logic [7:0] mosi_log [0:255];
    logic [7:0] rd_log [0:63];

    int         edge_base = 0;
    int         hdr_bits = 32;
    int         mbase = 0, rbase = 0, dbase = 0, hbase = 0;
    logic [7:0] resp [0:3];

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            bitph = 0;
        end else begin
            sh = {sh[6:0], mosi};
            bitph++;
            total_edges++;
            if (bitph == 8) begin
                mosi_log[mosi_n & 255] = sh;
                mosi_n++;
                bitph = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid) begin
            rd_log[rd_n & 63] = rd_data;
            rd_n++;
        end
        if (done) done_n++;
        if (wr_valid && wr_ready) hs_n++;
    end

    always_comb begin
        int e;
        e = total_edges - edge_base - hdr_bits;
        miso = 1'b0;
        if (e >= 0 && e < 32) miso = resp[e / 8][7 - (e % 8)];
    end

    // ---------------- stimulus helpers ----------------
    task automatic kick(input logic [7:0] op, input logic [23:0] a, input logic [23:0] len, input int hdr);
        @(posedge clk); #1;
        edge_base = total_edges;
        hdr_bits  = hdr;
        mbase = mosi_n; rbase = rd_n; dbase = done_n; hbase = hs_n;
        inst = op; address = a; byte_length = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_n == dbase && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done seen"}, 32'(done_n != dbase), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " wr_ready seen"}, 32'(wr_ready), 32'd1);
    endtask

    task automatic check_mosi(input string tag, input logic [63:0] exp, input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s mosi byte %0d", tag, i), 32'(mosi_log[(mbase + i) & 255]),
                  32'(exp[8*(n-1-i) +: 8]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int snap;
        int n;
        for (int i = 0; i < 4; i++) resp[i] = 8'h00;

        // ---- reset state ----
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset cs_n", 32'(cs_n), 32'd1);
        check("reset sclk", 32'(sclk), 32'd0);
        check("reset mosi", 32'(mosi), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done/rd_valid/wr_ready", {29'd0, done, rd_valid, wr_ready}, 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // ---- 1: READ 0x000010 len 2 ----
        resp[0] = 8'hA5; resp[1] = 8'h3C;
        kick(8'h03, 24'h000010, 24'd2, 32);
        check("t1 busy after start", 32'(busy), 32'd1);
        wait_done("t1");
        check("t1 edges", 32'(total_edges - edge_base), 32'd48);
        check_mosi("t1", 64'h0000_0000_0300_0010, 4);
        check("t1 rd count", 32'(rd_n - rbase), 32'd2);
        check("t1 rd byte0", 32'(rd_log[rbase & 63]), 32'hA5);
        check("t1 rd byte1", 32'(rd_log[(rbase + 1) & 63]), 32'h3C);
        check("t1 done count", 32'(done_n - dbase), 32'd1);
        check("t1 cs_n after", 32'(cs_n), 32'd1);
        check("t1 busy after", 32'(busy), 32'd0);

        // ---- 2: WRITE 0x0001FF len 3 with a stall before byte 2 ----
        resp[0] = 8'h00; resp[1] = 8'h00;
        wr_data = 8'h11; wr_valid = 1'b1;
        kick(8'h02, 24'h0001FF, 24'd3, 32);
        wait_ready("t2 b0");
        @(posedge clk); #1;
        wr_valid = 1'b0; wr_data = 8'h22;
        wait_ready("t2 b1");
        viol = 0;
        snap = total_edges;
        repeat (20) begin
            @(negedge clk);
            if (sclk !== 1'b0 || cs_n !== 1'b0 || wr_ready !== 1'b1) viol++;
        end
        check("t2 stall pins", 32'(viol), 32'd0);
        check("t2 stall edges", 32'(total_edges - snap), 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_data = 8'h33;
        wait_ready("t2 b2");
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_done("t2");
        check("t2 edges", 32'(total_edges - edge_base), 32'd56);
        check_mosi("t2", 64'h0002_0001_FF11_2233, 7);
        check("t2 handshakes", 32'(hs_n - hbase), 32'd3);
        check("t2 done count", 32'(done_n - dbase), 32'd1);
        check("t2 rd count", 32'(rd_n - rbase), 32'd0);

        // ---- 3a: RDSR, miso 0x40 ----
        resp[0] = 8'h40;
        kick(8'h05, 24'hABCDEF, 24'd9, 8);
        wait_done("t3 rdsr");
        check("t3 rdsr edges", 32'(total_edges - edge_base), 32'd16);
        check("t3 rdsr rd count", 32'(rd_n - rbase), 32'd1);
        check("t3 rdsr rd_data", 32'(rd_data), 32'h40);
        check_mosi("t3 rdsr", 64'h05, 1);

        // ---- 3b: WRSR 0x00 ----
        resp[0] = 8'h00;
        wr_data = 8'h00; wr_valid = 1'b1;
        kick(8'h01, 24'h000000, 24'd5, 8);
        wait_ready("t3 wrsr");
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_done("t3 wrsr");
        check("t3 wrsr edges", 32'(total_edges - edge_base), 32'd16);
        check("t3 wrsr handshakes", 32'(hs_n - hbase), 32'd1);
        check_mosi("t3 wrsr", 64'h0100, 2);

        // ---- 4: unsupported opcode 0x9F ----
        kick(8'h9F, 24'h000000, 24'd1, 32);
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("t4 pins idle", 32'(viol), 32'd0);
        check("t4 edges", 32'(total_edges - edge_base), 32'd0);
        check("t4 done count", 32'(done_n - dbase), 32'd0);

        // ---- 5: reset at 10th rising edge of a WRITE, then READ len 1 ----
        wr_data = 8'h77; wr_valid = 1'b1;
        kick(8'h02, 24'h123456, 24'd4, 32);
        n = 0;
        while ((total_edges - edge_base) < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t5 reached edge 10", 32'(total_edges - edge_base), 32'd10);
        rst = 1'b1;
        #1;
        check("t5 async cs_n", 32'(cs_n), 32'd1);
        check("t5 async sclk", 32'(sclk), 32'd0);
        check("t5 async busy", 32'(busy), 32'd0);
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        resp[0] = 8'h5A;
        kick(8'h03, 24'h000020, 24'd1, 32);
        wait_done("t5 read");
        check("t5 read edges", 32'(total_edges - edge_base), 32'd40);
        check_mosi("t5 read", 64'h0300_0020, 4);
        check("t5 rd count", 32'(rd_n - rbase), 32'd1);
        check("t5 rd byte", 32'(rd_log[rbase & 63]), 32'h5A);
        check("t5 done count", 32'(done_n - dbase), 32'd1);

        // ---- 6: READ len 0 ----
        resp[0] = 8'hFF;
        kick(8'h03, 24'h000100, 24'd0, 32);
        wait_done("t6");
        check("t6 edges", 32'(total_edges - edge_base), 32'd32);
        check("t6 rd count", 32'(rd_n - rbase), 32'd0);
        check("t6 done count", 32'(done_n - dbase), 32'd1);
        check_mosi("t6", 64'h0300_0100, 4);
        check("t6 cs_n after", 32'(cs_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_spi_master.md
Name: sram_spi_master

Overview:
- Parametrised SPI mode-0 master for serial SRAM (23LC-class), successor to the sclk-domain read/write controller.
- Runs on the system clock and generates SCLK internally through a programmable divider.
- Supports READ, WRITE, RDSR and WRSR, with byte-wide valid/ready data streams and write-underflow stalling.
- Sits between the Raspberry Pi accelerator command logic and the external SRAM pins.

Parameters:
ADDR_BYTES, 3, number of address bytes sent after READ/WRITE opcode (1..4)
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
LEN_W, 24, width of byte_length

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  command request, sampled in IDLE only
inst  input  8  opcode: 0x03 READ, 0x02 WRITE, 0x05 RDSR, 0x01 WRSR
address  input  8*ADDR_BYTES  SRAM address, captured at start
byte_length  input  LEN_W  data bytes for READ/WRITE, captured at start
wr_data  input  8  next write byte
wr_valid  input  1  wr_data valid
wr_ready  output  1  write byte accepted when wr_valid&wr_ready
rd_data  output  8  received byte
rd_valid  output  1  one-cycle pulse per received byte, no backpressure
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
cs_n  output  1  SRAM chip select, active-low
sclk  output  1  SPI clock, idles low
mosi  output  1  SPI data out
miso  input  1  SPI data in

Behaviour:
- Reset values (async, take effect immediately, including mid-transfer): cs_n=1, sclk=0, mosi=0, busy=0, done=0, rd_valid=0, wr_ready=0, rd_data=0; FSM=IDLE; divider and counters=0.
- FSM states:
  - IDLE -> CS_SETUP on start with a supported inst.
  - CS_SETUP (cs_n low for one half-period) -> CMD.
  - CMD (8 bits) -> ADDR for READ/WRITE, DATA for RDSR/WRSR.
  - ADDR (8*ADDR_BYTES bits) -> DATA, or CS_HOLD when byte_length=0.
  - DATA -> CS_HOLD after the last byte.
  - CS_HOLD (one half-period, sclk low) -> IDLE; cs_n=1 and done=1 in the same cycle.
- Unsupported inst: start ignored; no pin activity, busy stays 0, no done.
- busy rises the cycle after start is accepted and falls with the done pulse.
- SPI timing:
  - MSB first; mosi updates on sclk falling edge; first bit is valid on cs_n fall.
  - miso sampled on sclk rising edge; sclk toggles every CLK_DIV clk cycles while active.
- Byte count: RDSR/WRSR always 1 data byte, byte_length ignored. READ/WRITE send byte_length bytes; 0 = opcode+address only.
- Write path:
  - wr_ready is high for one cycle per byte, in the half-period before that byte's first bit; the byte is loaded on the handshake.
  - If wr_valid is low when the byte is needed: stall with sclk held low, cs_n held low, wr_ready held high, until valid.
- Read path: rd_valid pulses for one cycle after the 8th rising edge of each data byte; rd_data holds until the next pulse.
- Total SCLK rising edges per transaction = 8 + 8*ADDR_BYTES*(isRW) + 8*nbytes.
- Bit counter is 3 bits; byte counter is LEN_W bits, decrements to 0, no wrap.
- start while busy: ignored.

Optional Feature:
SRAM_SPI_INIT_SEQ_EN
- Defined: after rst deasserts, the block autonomously issues WRSR with data 0x40 (sequential mode). busy=1 throughout, no done pulse, wr_ready stays 0, start ignored until it completes.
- Not defined: block is IDLE and accepts start on the first cycle after reset.

Test Plan:
1. CLK_DIV=2, READ addr 0x000010 len 2, miso drives 0xA5,0x3C -> mosi bytes 0x03,0x00,0x00,0x10; 48 rising edges; rd_valid pulses with 0xA5 then 0x3C; single done; cs_n=1 after.
2. WRITE addr 0x0001FF len 3, data 0x11,0x22,0x33, wr_valid withheld 20 clk before byte 2 -> sclk frozen low with cs_n low during the gap; mosi 0x02,0x00,0x01,0xFF,0x11,0x22,0x33; 56 rising edges; done once.
3. RDSR with miso 0x40 -> 16 rising edges, rd_data=0x40, rd_valid 1 pulse; WRSR 0x00 -> 16 edges, 1 wr_ready handshake.
4. inst 0x9F with start=1 -> cs_n stays 1, sclk static, busy=0, no done.
5. rst pulsed at the 10th rising edge of a WRITE -> cs_n=1 and sclk=0 before the next clk edge, busy=0; a following READ len 1 completes correctly.
6. READ len 0 -> 32 rising edges, no rd_valid, done pulse; with SRAM_SPI_INIT_SEQ_EN, reset release -> mosi 0x01,0x40 on 16 edges, no done, then start accepted.
